// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the 8-tap fixed-coefficient FIR.
//   TAPS / DW / CW  : tap count, sample width, coefficient width (Q1.15)
//   ACC_W           : exact MAC width, DW + CW + log2(TAPS)
//   FIR_COEFFS      : symmetric low-pass table, DC gain 30720/32768
//   sample_t        : signed audio sample
package fir_pkg;

    localparam int TAPS  = 8;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int ACC_W = DW + CW + $clog2(TAPS);

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [CW-1:0] coeff_t;

    localparam coeff_t FIR_COEFFS [TAPS] = '{
        16'sd1024, 16'sd2048, 16'sd4096, 16'sd8192,
        16'sd8192, 16'sd4096, 16'sd2048, 16'sd1024
    };

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round-half-up and saturate of the MAC result.
//   acc    : ACC_W-bit signed accumulator (Q.15 scaled)
//   sample : DW-bit signed result, (acc + 2^14) >>> 15 clamped to DW bits
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int AW  = fir_pkg::ACC_W,
    parameter int OW  = fir_pkg::DW
) (
    input  logic [AW-1:0] acc,
    output logic [OW-1:0] sample
);

    localparam logic signed [AW-1:0] HALF_LSB = {{(AW-15){1'b0}}, 1'b1, 14'b0};
    localparam logic signed [AW-1:0] MAX_S    = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_S    = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [AW-1:0] rounded_s;
    logic signed [AW-1:0] shifted_s;

    // round half up, then clamp into the output sample range
    always_comb begin
        rounded_s = $signed(acc) + HALF_LSB;
        shifted_s = rounded_s >>> 15;
        if (shifted_s > MAX_S) begin
            sample = MAX_S[OW-1:0];
        end else if (shifted_s < MIN_S) begin
            sample = MIN_S[OW-1:0];
        end else begin
            sample = shifted_s[OW-1:0];
        end
    end

endmodule

// File: rtl/fir.sv
// fir: 8-tap fixed-coefficient low-pass FIR, one sample per clock, no stalls.
//   clk      : rising-edge clock
//   reset    : synchronous active-high; clears the delay line and output
//   data_in  : signed input sample, captured every edge
//   data_out : signed filtered sample, registered
module fir
    import fir_pkg::*;
#(
    parameter int TAPS = fir_pkg::TAPS,
    parameter int DW   = fir_pkg::DW,
    parameter int CW   = fir_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    localparam int PW = DW + CW;
    localparam int AW = DW + CW + $clog2(TAPS);

    logic [DW-1:0] x_r [TAPS];
    logic [PW-1:0] prod_s [TAPS];
    logic [AW-1:0] ext_s [TAPS];
    logic [AW-1:0] acc_s;
    logic [DW-1:0] rs_sample_s;
    logic [DW-1:0] data_out_r;

    // per-tap products: operands sign-extended to full product width so the
    // low PW bits are the exact signed product
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic signed [PW-1:0] xe_s;
        logic signed [PW-1:0] ce_s;
        assign xe_s      = {{(PW-DW){x_r[k][DW-1]}}, x_r[k]};
        assign ce_s      = {{(PW-CW){FIR_COEFFS[k][CW-1]}}, FIR_COEFFS[k]};
        assign prod_s[k] = xe_s * ce_s;
        assign ext_s[k]  = {{(AW-PW){prod_s[k][PW-1]}}, prod_s[k]};
    end

    // single-cycle adder tree over the pre-edge delay line
    always_comb begin
        acc_s = {AW{1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            acc_s = acc_s + ext_s[k];
        end
    end

    fir_round_sat #(
        .AW (AW),
        .OW (DW)
    ) u_round_sat (
        .acc    (acc_s),
        .sample (rs_sample_s)
    );

    // delay line: newest sample at x_r[0]
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_r[k] <= {DW{1'b0}};
            end
        end else begin
            x_r[0] <= data_in;
            for (int k = 1; k < TAPS; k++) begin
                x_r[k] <= x_r[k-1];
            end
        end
    end

    // output register
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= {DW{1'b0}};
        end else begin
            data_out_r <= rs_sample_s;
        end
    end

    assign data_out = data_out_r;

endmodule

// File: tb/tb_fir.sv
module tb_fir;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    int coef [8] = '{1024, 2048, 4096, 8192, 8192, 4096, 2048, 1024};
    int hist [8];
    int expected;
    int impulse [9] = '{512, 1024, 2048, 4096, 4096, 2048, 1024, 512, 0};

    fir dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: output is the rounded, clamped dot product of the
    // history before the edge; history then shifts in the new sample.
    function automatic int model_out();
        longint acc = 0;
        longint r;
        for (int k = 0; k < 8; k++) acc += longint'(coef[k]) * longint'(hist[k]);
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic step(input logic rst, input int d, input string tag);
        reset   = rst;
        data_in = d[15:0];
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 8; k++) hist[k] = 0;
            expected = 0;
        end else begin
            expected = model_out();
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
        end
        @(negedge clk);
        check(tag, int'($signed(data_out)), expected);
    endtask

    task automatic flush();
        for (int i = 0; i < 9; i++) step(1'b0, 0, "flush");
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 16'h0000;
        for (int k = 0; k < 8; k++) hist[k] = 0;

        // reset with arbitrary input
        for (int i = 0; i < 3; i++) step(1'b1, int'($urandom_range(0, 65535)) - 32768, "reset_hold");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, "post_reset_zero");
            check("post_reset_const", int'($signed(data_out)), 0);
        end

        // impulse
        step(1'b0, 16384, "impulse_in");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 0, "impulse");
            check("impulse_const", int'($signed(data_out)), impulse[i]);
        end

        // positive step
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 32767, "pos_step");
            if (i >= 8) check("pos_settle", int'($signed(data_out)), 30719);
            check("pos_sign", int'(data_out[15]), 0);
        end
        flush();

        // negative step
        for (int i = 0; i < 14; i++) begin
            step(1'b0, -32768, "neg_step");
            if (i >= 8) check("neg_settle", int'($signed(data_out)), -30720);
            if (i >= 1) check("neg_sign", int'(data_out[15]), 1);
        end
        flush();

        // rounding: tiny impulse of 1 never rounds up
        step(1'b0, 1, "round1_in");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 0, "round1");
            check("round1_const", int'($signed(data_out)), 0);
        end

        // rounding: impulse of 16, peak tap gives 4
        step(1'b0, 16, "round16_in");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 0, "round16");
            if (i == 3) check("round16_peak", int'($signed(data_out)), 4);
        end

        // random stream
        for (int i = 0; i < 300; i++)
            step(1'b0, int'($urandom_range(0, 65535)) - 32768, "random");

        // mid-stream reset then impulse
        for (int i = 0; i < 20; i++)
            step(1'b0, int'($urandom_range(0, 65535)) - 32768, "pre_reset");
        step(1'b1, int'($urandom_range(0, 65535)) - 32768, "mid_reset");
        step(1'b0, 16384, "mid_impulse_in");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 0, "mid_impulse");
            check("mid_impulse_const", int'($signed(data_out)), impulse[i]);
        end

        // random stream with occasional resets
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 31) == 0), int'($urandom_range(0, 65535)) - 32768, "random_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
